// File: rtl/wt_mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM states, partial-product
// shifts and the 3:2 / 2:2 counter helpers used by the 4x4 Wallace-tree core.
package wt_mult_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        PP0,
        PP1,
        PP2,
        PP3,
        DONE
    } state_t;

    localparam logic [3:0] PP0_SHIFT = 4'd0;
    localparam logic [3:0] PP1_SHIFT = 4'd4;
    localparam logic [3:0] PP2_SHIFT = 4'd4;
    localparam logic [3:0] PP3_SHIFT = 4'd8;

    // Full adder as a 3:2 counter, returns {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/WT_4bit_counter.sv
// Combinational 4x4 unsigned multiplier: one Wallace reduction layer of counters
// followed by a carry-propagate add of the remaining rows.
module WT_4bit_counter
    import wt_mult_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [3:0] pp [4];
    logic [1:0] h1, f2, f3, f4, h5;
    logic [7:0] row_x, row_y, row_z;

    // pp[i][j] carries weight i+j
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                pp[i][j] = a_i[j] & b_i[i];
            end
        end
    end

    assign h1 = ha(pp[0][1], pp[1][0]);
    assign f2 = fa(pp[0][2], pp[1][1], pp[2][0]);
    assign f3 = fa(pp[0][3], pp[1][2], pp[2][1]);
    assign f4 = fa(pp[1][3], pp[2][2], pp[3][1]);
    assign h5 = ha(pp[2][3], pp[3][2]);

    assign row_x = {1'b0, pp[3][3], h5[0], f4[0], f3[0], f2[0], h1[0], pp[0][0]};
    assign row_y = {1'b0, h5[1], f4[1], f3[1], f2[1], h1[1], 2'b00};
    assign row_z = {4'b0000, pp[3][0], 3'b000};

    assign p_o = row_x + row_y + row_z;

endmodule

// File: rtl/wt_8bit_seq_ctrl.sv
// Sequential 8x8 multiplier time-sharing one 4x4 core over four partial products.
// Define WT_SEQ_APPROX_LO_EN to skip the low*low partial product (approximate, 1 cycle faster).
module wt_8bit_seq_ctrl
    import wt_mult_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      c,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

`ifdef WT_SEQ_APPROX_LO_EN
    localparam state_t FIRST_PP = PP1;
`else
    localparam state_t FIRST_PP = PP0;
`endif

    state_t           state_q, state_d;
    logic [7:0]       a_q, b_q;
    logic [15:0]      acc_q, c_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [CNT_W-1:0] op_count_q;

    logic [3:0]       mul_a, mul_b, pp_shift;
    logic [7:0]       pp;
    logic [15:0]      pp_term, acc_sum;
    logic             accept, handshake;

    always_comb begin
        mul_a    = a_q[3:0];
        mul_b    = b_q[3:0];
        pp_shift = PP0_SHIFT;
        case (state_q)
            PP1: begin
                mul_a    = a_q[7:4];
                pp_shift = PP1_SHIFT;
            end
            PP2: begin
                mul_b    = b_q[7:4];
                pp_shift = PP2_SHIFT;
            end
            PP3: begin
                mul_a    = a_q[7:4];
                mul_b    = b_q[7:4];
                pp_shift = PP3_SHIFT;
            end
            default: ;
        endcase
    end

    WT_4bit_counter u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (pp)
    );

    assign pp_term   = {8'h00, pp} << pp_shift;
    assign acc_sum   = acc_q + pp_term;
    assign accept    = (state_q == IDLE) && in_valid;
    assign handshake = (state_q == DONE) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = FIRST_PP;
            PP0:     state_d = PP1;
            PP1:     state_d = PP2;
            PP2:     state_d = PP3;
            PP3:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == DONE);
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                acc_q <= '0;
            end else if (state_q inside {PP0, PP1, PP2, PP3}) begin
                acc_q <= acc_sum;
                if (state_q == PP3) begin
                    c_q <= acc_sum;
                end
            end
            if (handshake) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign c         = c_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_wt_8bit_seq_ctrl.sv
// Self-checking bench: transaction-level reference model compared every cycle, plus
// directed literal cases for products, latency, stall, reset abort and counter wrap.
module tb_wt_8bit_seq_ctrl;

`ifdef WT_SEQ_APPROX_LO_EN
    localparam bit APPROX   = 1'b1;
    localparam int DONE_CYC = 4;
`else
    localparam bit APPROX   = 1'b0;
    localparam int DONE_CYC = 5;
`endif
    localparam int PERIOD = DONE_CYC + 1;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy;
    logic [15:0] c;
    logic [15:0] op_count;
    logic        in_ready2, out_valid2, busy2;
    logic [15:0] c2;
    logic [1:0]  op_count2;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    wt_8bit_seq_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .busy(busy), .op_count(op_count)
    );

    wt_8bit_seq_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .c(c2), .busy(busy2), .op_count(op_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        if (APPROX) p = p - int'(x[3:0]) * int'(y[3:0]);
        return p[15:0];
    endfunction

    // Transaction model: a product appears DONE_CYC cycles after its accept cycle
    // and is held until out_ready.
    bit          m_busy = 1'b0;
    int          m_cyc  = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_c    = '0;
    int unsigned m_ops  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cyc  = 0;
            m_c    = '0;
            m_ops  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cyc  = 1;
                m_pend = ref_prod(a, b);
            end
        end else if (m_cyc < DONE_CYC) begin
            m_cyc++;
            if (m_cyc == DONE_CYC) m_c = m_pend;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_ops++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  32'(in_ready),  32'(!m_busy));
            check("busy",      32'(busy),      32'(m_busy));
            check("out_valid", 32'(out_valid), 32'(m_busy && m_cyc == DONE_CYC));
            check("c",         32'(c),         32'(m_c));
            check("op_count",  32'(op_count),  32'(m_ops[15:0]));
            check("c_w2",      32'(c2),        32'(m_c));
            check("op_count_w2", 32'(op_count2), 32'(m_ops[1:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair from IDLE; returns the cycle index (accept cycle = 0)
    // at which out_valid is first seen.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp_c, input string tag);
        int lat;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        lat = 1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_seen"}, 32'(out_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(DONE_CYC));
        check({tag, "_c"}, 32'(c), 32'(exp_c));
    endtask

    initial begin
        int acc_t[3];
        int n_acc;
        int cyc;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        run_op(8'hFF, 8'hFF, APPROX ? 16'hFD20 : 16'hFE01, "ffxff");
        tick();
        check("ffxff_op_count", 32'(op_count), 32'd1);
        check("ffxff_c_hold", 32'(c), APPROX ? 32'hFD20 : 32'hFE01);

        run_op(8'h12, 8'h34, APPROX ? 16'h03A0 : 16'h03A8, "12x34");
        tick();
        check("12x34_op_count", 32'(op_count), 32'd2);

        out_ready = 1'b0;
        run_op(8'hA5, 8'h3C, APPROX ? 16'h2670 : 16'h26AC, "stall");
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_c", 32'(c), APPROX ? 32'h2670 : 32'h26AC);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_op_count", 32'(op_count), 32'd2);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        check("stall_release_op_count", 32'(op_count), 32'd3);
        check("stall_release_out_valid", 32'(out_valid), 32'd0);
        check("stall_release_in_ready", 32'(in_ready), 32'd1);

        a = 8'h77;
        b = 8'h99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < (APPROX ? 1 : 2); i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_c", 32'(c), 32'd0);
        check("abort_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end

        n_acc = 0;
        cyc = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (n_acc < 3 && cyc < 40) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (in_ready) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(n_acc), 32'd3);
        check("stream_gap1", 32'(acc_t[1] - acc_t[0]), 32'(PERIOD));
        check("stream_gap2", 32'(acc_t[2] - acc_t[1]), 32'(PERIOD));
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("stream_drained", 32'(in_ready), 32'd1);
        check("stream_op_count", 32'(op_count), 32'd3);

        run_op(8'h0F, 8'hF0, 16'h0E10, "0fxf0");
        tick();
        run_op(8'h80, 8'h02, 16'h0100, "80x02");
        tick();
        check("wrap_op_count", 32'(op_count), 32'd5);
        check("wrap_op_count_w2", 32'(op_count2), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(99) < 50);
            out_ready = ($urandom_range(99) < 60);
            a = 8'($urandom);
            b = 8'($urandom);
            rst = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
